mac_operand_feeder: RTL and testbench

//  Source side of the MACUnit operand interface: produces FM, WM and WEn for one column of ROWS MAC cells.

---
 rtl/mac_operand_feeder.sv | 209 ++++++++++++++++++++
 tb/tb_mac_operand_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder
//   Source side of the MAC operand interface for one column of ROWS cells.
//   Loads a weight vector (single-cycle WEn to every row), then streams
//   num_vec activation vectors with systolic skew: lane r sees its operand
//   r cycles after lane 0. Every output comes straight from a flop or from
//   the state/counter flops, so there is no path from in_* to an output.
//
//   Optional build macro FEEDER_STALL_CNT_EN adds output stall_cnt: the
//   number of STREAM cycles with in_valid low. It clears on an accepted
//   start, saturates at all ones and holds after the job ends.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start; in_ready low
//   S_LOAD_W | waiting for the weight beat; in_ready high
//   S_STREAM | accepting activation beats until num_vec have been taken
//   S_FLUSH  | ROWS-1 cycles of bubbles so the last lane drains
//   S_DONE   | final cycle of the job; done pulses on the following cycle

module mac_operand_feeder #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_vec,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_fm,
    input  logic [ROWS*DATA_W-1:0] in_wm,
    output logic [ROWS*DATA_W-1:0] fm_out,
    output logic [ROWS-1:0]        fm_vld,
    output logic [ROWS*DATA_W-1:0] wm_out,
    output logic [ROWS-1:0]        wen_out,
    output logic                   busy,
    output logic                   done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]       stall_cnt
`endif
);

    // Flush length is ROWS-1; keep the counter at least one bit wide.
    localparam int FL_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        num_vec_q, num_vec_d;
    logic [CNT_W-1:0]        vec_cnt_q, vec_cnt_d;
    logic [FL_W-1:0]         flush_cnt_q, flush_cnt_d;
    logic [ROWS*DATA_W-1:0]  wm_q, wm_d;
    logic [ROWS-1:0]         wen_q, wen_d;
    logic                    done_q, done_d;
    logic                    fm_take;

    // Next-state, counters, weight capture and handshake.
    always_comb begin
        state_d     = state_q;
        num_vec_d   = num_vec_q;
        vec_cnt_d   = vec_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wm_d        = wm_q;
        wen_d       = '0;
        done_d      = 1'b0;
        in_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_vec != '0) begin
                        num_vec_d = num_vec;
                        vec_cnt_d = '0;
                        state_d   = S_LOAD_W;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD_W: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wm_d    = in_wm;
                    wen_d   = '1;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                in_ready = (vec_cnt_q < num_vec_q);
                if (in_valid && in_ready) begin
                    vec_cnt_d = vec_cnt_q + CNT_W'(1);
                    if (vec_cnt_q == num_vec_q - CNT_W'(1)) begin
                        if (ROWS == 1) begin
                            state_d = S_DONE;
                        end else begin
                            flush_cnt_d = FL_W'(ROWS - 1);
                            state_d     = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                flush_cnt_d = flush_cnt_q - FL_W'(1);
                if (flush_cnt_q == FL_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and weight registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            num_vec_q   <= '0;
            vec_cnt_q   <= '0;
            flush_cnt_q <= '0;
            wm_q        <= '0;
            wen_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            vec_cnt_q   <= vec_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wm_q        <= wm_d;
            wen_q       <= wen_d;
            done_q      <= done_d;
        end
    end

    assign fm_take = (state_q == S_STREAM) && in_valid && in_ready;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign wm_out  = wm_q;
    assign wen_out = wen_q;

    // Per-lane skew pipes: lane r holds r+1 stages of {vld, data}; a cycle
    // without a transfer pushes a zero bubble.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_W:0] stg_q [0:r];
        logic [DATA_W:0] stg_d [0:r];

        // Stage 0 takes the accepted lane operand, later stages shift.
        always_comb begin
            stg_d[0] = {fm_take, in_fm[r*DATA_W +: DATA_W] & {DATA_W{fm_take}}};
            for (int s = 1; s <= r; s++) begin
                stg_d[s] = stg_q[s-1];
            end
        end

        // Skew stage registers, free-running.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= r; s++) begin
                    stg_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s <= r; s++) begin
                    stg_q[s] <= stg_d[s];
                end
            end
        end

        assign fm_out[r*DATA_W +: DATA_W] = stg_q[r][DATA_W-1:0];
        assign fm_vld[r]                  = stg_q[r][DATA_W];
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Count starved STREAM cycles; cleared by an accepted start, saturating.
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start) begin
            stall_d = '0;
        end else if (state_q == S_STREAM && !in_valid && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Testbench for mac_operand_feeder: directed jobs checked every cycle
// against a cycle-indexed transfer log, plus literal latency/count checks.
module tb_mac_operand_feeder;

    localparam int ROWS   = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int W      = ROWS * DATA_W;
    localparam int MAXC   = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vec = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_fm = '0;
    logic [W-1:0]     in_wm = '0;
    logic [W-1:0]     fm_out;
    logic [ROWS-1:0]  fm_vld;
    logic [W-1:0]     wm_out;
    logic [ROWS-1:0]  wen_out;
    logic             busy;
    logic             done;
`ifdef FEEDER_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    mac_operand_feeder #(.ROWS(ROWS), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_vec  (num_vec),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_fm    (in_fm),
        .in_wm    (in_wm),
        .fm_out   (fm_out),
        .fm_vld   (fm_vld),
        .wm_out   (wm_out),
        .wen_out  (wen_out),
        .busy     (busy),
        .done     (done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Model: per-cycle log of accepted activation beats plus job bookkeeping.
    logic         xv [0:MAXC-1];
    logic [W-1:0] xd [0:MAXC-1];
    logic         m_active = 1'b0;
    logic         m_wdone  = 1'b0;
    int           m_acc = 0, m_num = 0, m_last = -1, done_cyc = -1, wen_cyc = -1;
    logic [W-1:0] m_wm = '0;
    int           m_stall = 0;

    // Monitors feeding the literal checks.
    int lane_cnt [ROWS];
    int lane_sum [ROWS];
    int last_vld [ROWS];
    int done_tot = 0, done_last = -1, wen_tot = 0;

    logic [W-1:0]    fm_e;
    logic [ROWS-1:0] vld_e;
    logic            rdy_e;

    initial begin
        for (int r = 0; r < ROWS; r++) begin
            lane_cnt[r] = 0;
            lane_sum[r] = 0;
            last_vld[r] = -1;
        end
    end

    // Compare outputs with the model, then fold this cycle's inputs into it.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_fm", fm_out, '0);
            chk("rst_vld", fm_vld, '0);
            chk("rst_wm", wm_out, '0);
            chk("rst_wen", wen_out, '0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rdy", in_ready, 0);
            m_active = 1'b0;
            m_wdone  = 1'b0;
            m_last   = -1;
            done_cyc = -1;
            wen_cyc  = -1;
            m_wm     = '0;
            m_stall  = 0;
            for (int i = 0; i < MAXC; i++) xv[i] = 1'b0;
        end else begin
            fm_e  = '0;
            vld_e = '0;
            for (int r = 0; r < ROWS; r++) begin
                if (cyc - 1 - r >= 0 && xv[cyc-1-r]) begin
                    vld_e[r] = 1'b1;
                    fm_e[r*DATA_W +: DATA_W] = xd[cyc-1-r][r*DATA_W +: DATA_W];
                end
            end
            rdy_e = m_active && (!m_wdone || (m_acc < m_num));
            chk("fm_out", fm_out, fm_e);
            chk("fm_vld", fm_vld, vld_e);
            chk("wm_out", wm_out, m_wm);
            chk("wen_out", wen_out, (cyc == wen_cyc) ? {ROWS{1'b1}} : '0);
            chk("busy", busy, m_active);
            chk("done", done, (cyc == done_cyc));
            chk("in_ready", in_ready, rdy_e);
`ifdef FEEDER_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
            for (int r = 0; r < ROWS; r++) begin
                if (fm_vld[r]) begin
                    lane_cnt[r]++;
                    lane_sum[r] += int'(fm_out[r*DATA_W +: DATA_W]);
                    last_vld[r] = cyc;
                end
            end
            if (done) begin
                done_tot++;
                done_last = cyc;
            end
            if (wen_out != '0) wen_tot++;

            if (!m_active) begin
                if (start) begin
                    m_stall = 0;
                    if (num_vec != '0) begin
                        m_active = 1'b1;
                        m_wdone  = 1'b0;
                        m_acc    = 0;
                        m_num    = int'(num_vec);
                        m_last   = -1;
                    end else begin
                        done_cyc = cyc + 1;
                    end
                end
            end else begin
                if (m_wdone && m_acc < m_num && !in_valid && m_stall < 65535) m_stall++;
                if (rdy_e && in_valid) begin
                    if (!m_wdone) begin
                        m_wdone = 1'b1;
                        m_wm    = in_wm;
                        wen_cyc = cyc + 1;
                    end else begin
                        xv[cyc] = 1'b1;
                        xd[cyc] = in_fm;
                        m_acc++;
                        if (m_acc == m_num) begin
                            m_last   = cyc;
                            done_cyc = cyc + ROWS + 1;
                        end
                    end
                end
                if (m_last >= 0 && cyc == m_last + ROWS) m_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0, input string nm);
        for (int i = 0; i < 60 && done_tot == d0; i++) tick();
        if (done_tot == d0) begin
            nchk++;
            nerr++;
            $display("FAIL %s timeout got=no_done want=done", nm);
        end
    endtask

    task automatic begin_job(input logic [CNT_W-1:0] n, input logic [W-1:0] w);
        start    = 1'b1;
        num_vec  = n;
        in_valid = 1'b0;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_wm    = w;
        in_fm    = 32'hDEADBEEF;
        tick();
        in_wm    = 32'hA5A5A5A5;
    endtask

    logic [W-1:0] fmv [3];
    int c0 [ROWS];
    int s0 [ROWS];
    int t, d0, w0;

    initial begin
        fmv[0] = 32'h04030201;
        fmv[1] = 32'h08070605;
        fmv[2] = 32'h0C0B0A09;

        repeat (3) tick();
        rst = 1'b1;
        tick();

        // T2: back-to-back job of three vectors.
        c0 = lane_cnt; s0 = lane_sum; d0 = done_tot; w0 = wen_tot;
        begin_job(16'd3, 32'h04030201);
        t = cyc;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_fm    = fmv[i];
            tick();
        end
        in_valid = 1'b0;
        in_fm    = '0;
        wait_done(d0, "t2_wait");
        chk("t2_wm", wm_out, 32'h04030201);
        chk("t2_wen_cycles", wen_tot - w0, 1);
        chk("t2_lane0_cnt", lane_cnt[0] - c0[0], 3);
        chk("t2_lane3_cnt", lane_cnt[3] - c0[3], 3);
        chk("t2_lane0_sum", lane_sum[0] - s0[0], 15);
        chk("t2_lane3_sum", lane_sum[3] - s0[3], 24);
        chk("t2_lane0_last", last_vld[0] - t, 3);
        chk("t2_lane3_last", last_vld[3] - t, 6);
        chk("t2_done_lat", done_last - t, 7);
        chk("t2_done_after_lane3", done_last - last_vld[3], 1);

        // T3: gapped stream 1,0,1,0,1.
        c0 = lane_cnt; d0 = done_tot;
        begin_job(16'd3, 32'h11223344);
        t = cyc;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_fm    = (i % 2 == 0) ? fmv[i/2] : 32'hFFFFFFFF;
            tick();
        end
        in_valid = 1'b0;
        in_fm    = '0;
        wait_done(d0, "t3_wait");
        chk("t3_lane2_cnt", lane_cnt[2] - c0[2], 3);
        chk("t3_lane1_last", last_vld[1] - t, 6);
        chk("t3_lane3_last", last_vld[3] - t, 8);
        chk("t3_done_lat", done_last - t, 9);
        chk("t3_wm", wm_out, 32'h11223344);
`ifdef FEEDER_STALL_CNT_EN
        chk("t6_stall_at_done", stall_cnt, 2);
`endif

        // T4a: zero-length job.
        d0 = done_tot; w0 = wen_tot;
        start   = 1'b1;
        num_vec = '0;
        tick();
        start   = 1'b0;
        chk("t4_done_pulse", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_rdy", in_ready, 0);
        tick();
        chk("t4_done_once", done_tot - d0, 1);
        chk("t4_no_wen", wen_tot - w0, 0);

        // T4b + T5: start while busy, in_valid held high past the last beat.
        c0 = lane_cnt; s0 = lane_sum; d0 = done_tot;
        begin_job(16'd3, 32'h01010101);
        t = cyc;
        for (int i = 0; i < 3; i++) begin
            in_fm   = fmv[i];
            start   = (i == 1);
            num_vec = 16'd5;
            tick();
        end
        start = 1'b0;
        in_fm = 32'hEEEEEEEE;
        wait_done(d0, "t5_wait");
        repeat (3) tick();
        chk("t5_rdy_idle", in_ready, 0);
        chk("t5_busy_idle", busy, 0);
        in_valid = 1'b0;
        chk("t5_lane3_cnt", lane_cnt[3] - c0[3], 3);
        chk("t5_lane0_sum", lane_sum[0] - s0[0], 15);
        chk("t4_done_lat", done_last - t, 7);
        chk("t4_single_done", done_tot - d0, 1);

        // T1: reset in the middle of STREAM.
        d0 = done_tot;
        begin_job(16'd5, 32'h0F0F0F0F);
        for (int i = 0; i < 2; i++) begin
            in_fm = fmv[i];
            tick();
        end
        rst = 1'b0;
        #1;
        chk("t1_busy_now", busy, 0);
        chk("t1_vld_now", fm_vld, '0);
        chk("t1_wm_now", wm_out, '0);
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (8) tick();
        chk("t1_no_done", done_tot - d0, 0);
        chk("t1_idle_busy", busy, 0);

        // Recovery: one-vector job after reset.
        c0 = lane_cnt; d0 = done_tot;
        begin_job(16'd1, 32'h0A0B0C0D);
        in_fm = fmv[2];
        tick();
        in_valid = 1'b0;
        wait_done(d0, "rec_wait");
        chk("rec_lane3_cnt", lane_cnt[3] - c0[3], 1);
        chk("rec_wm", wm_out, 32'h0A0B0C0D);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
